// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and default sizing for the writeback stage
package wb_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    WAIT_LD = 2'd2
  } wb_state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_RA_IDX   = 15;
  localparam int DEF_PC_INC   = 4;

  // Control flags of the held entry; the data fields are sized per instance.
  typedef struct packed {
    logic is_wb;
    logic is_ld;
    logic is_call;
  } entry_ctl_t;

endpackage

// File: rtl/wb_stage_rf_if.sv
// rtl/wb_stage_rf_if.sv - retired-instruction handshake from the memory stage
interface wb_stage_rf_if #(
  parameter int DATA_W = wb_pkg::DEF_DATA_W,
  parameter int REG_AW = $clog2(wb_pkg::DEF_NUM_REGS)
);
  logic              in_valid;
  logic              in_ready;
  logic              isWb;
  logic              isLd;
  logic              isCall;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] aluResult;
  logic [DATA_W-1:0] pc;

  modport master (
    output in_valid, isWb, isLd, isCall, rd, aluResult, pc,
    input  in_ready
  );

  modport slave (
    input  in_valid, isWb, isLd, isCall, rd, aluResult, pc,
    output in_ready
  );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - register file, one write port, two write-through read ports
module wb_regfile import wb_pkg::*; #(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int ZERO_REG_EN = 0,
  parameter int REG_AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  localparam bit ZERO_EN = (ZERO_REG_EN != 0);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (we && !(ZERO_EN && wa == '0)) begin
      mem_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Same-cycle write is forwarded so decode sees the committing value.
  always_comb begin
    rd1 = mem_q[rs1];
    if (we && wa == rs1) rd1 = wd;
    if (ZERO_EN && rs1 == '0) rd1 = '0;
    rd2 = mem_q[rs2];
    if (we && wa == rs2) rd2 = wd;
    if (ZERO_EN && rs2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/wb_stage_rf.sv
// rtl/wb_stage_rf.sv - writeback stage: entry register, load wait, result select, regfile
module wb_stage_rf import wb_pkg::*; #(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int RA_IDX      = DEF_RA_IDX,
  parameter int PC_INC      = DEF_PC_INC,
  parameter int ZERO_REG_EN = 0,
  parameter int REG_AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_rf_if.slave      mem,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ldResult,
  input  logic              flush,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              isWa,
  output logic [REG_AW-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              busy,
  output logic              ld_orphan
);
  localparam bit ZERO_EN = (ZERO_REG_EN != 0);

  wb_state_e         state_q, state_d;
  entry_ctl_t        ctl_q, ctl_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              ld_orphan_q, ld_orphan_d;

  logic              commit;
  logic              in_ready_c;
  logic              accept;
  logic [REG_AW-1:0] wa_sel;
  logic [DATA_W-1:0] wd_sel;

  always_comb begin
    commit     = !flush && (state_q == FULL || (state_q == WAIT_LD && ld_valid));
    in_ready_c = !flush && (state_q == EMPTY || commit);
    accept     = mem.in_valid && in_ready_c;

    state_d = state_q;
    ctl_d   = ctl_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    pc_d    = pc_q;
    if (flush) begin
      state_d = EMPTY;
      ctl_d   = '0;
    end else if (accept) begin
      state_d = mem.isLd ? WAIT_LD : FULL;
      ctl_d   = '{is_wb: mem.isWb, is_ld: mem.isLd, is_call: mem.isCall};
      rd_d    = mem.rd;
      alu_d   = mem.aluResult;
      pc_d    = mem.pc;
    end else if (commit) begin
      state_d = EMPTY;
    end

    // A flush swallows any coincident ld_valid without flagging it.
    ld_orphan_d = ld_orphan_q || (ld_valid && state_q != WAIT_LD && !flush);
  end

  always_comb begin
    wa_sel = ctl_q.is_call ? REG_AW'(RA_IDX) : rd_q;
    wd_sel = ctl_q.is_call ? pc_q + DATA_W'(PC_INC) :
             ctl_q.is_ld   ? ldResult : alu_q;
    isWa   = commit && ctl_q.is_wb && !(ZERO_EN && wa_sel == '0);
    wa     = commit ? wa_sel : '0;
    wd     = commit ? wd_sel : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      ctl_q       <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      pc_q        <= '0;
      ld_orphan_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      pc_q        <= pc_d;
      ld_orphan_q <= ld_orphan_d;
    end
  end

  assign mem.in_ready = in_ready_c;
  assign busy         = (state_q != EMPTY);
  assign ld_orphan    = ld_orphan_q;

  wb_regfile #(
    .DATA_W      (DATA_W),
    .NUM_REGS    (NUM_REGS),
    .ZERO_REG_EN (ZERO_REG_EN),
    .REG_AW      (REG_AW)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .we  (isWa),
    .wa  (wa),
    .wd  (wd),
    .rs1 (rs1),
    .rs2 (rs2),
    .rd1 (rd1),
    .rd2 (rd2)
  );

endmodule

// File: doc/wb_stage_rf.md
Name: wb_stage_rf

Overview:
- Parametrised writeback stage for the SimpleRISC pipeline. It adds a one-entry writeback register, variable-latency load completion, and the integrated register file with two bypassed read ports.
- Accepts retired instructions from the memory stage and selects write data with priority: call return address, then load data, then ALU result.
- Commits to the register file exactly once per accepted instruction.
- Feeds decode-stage operand reads.

Parameters:
- DATA_W, 32, datapath and register width.
- NUM_REGS, 16, number of architectural registers; REG_AW = clog2(NUM_REGS).
- RA_IDX, 15, register written by call instructions.
- PC_INC, 4, return-address offset added to pc on call.
- ZERO_REG_EN, 0, if 1 then register 0 reads as 0 and writes to it are dropped.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- isWb  in  1  instruction writes a register.
- isLd  in  1  instruction is a load; data arrives later on ldResult.
- isCall  in  1  instruction is a call.
- rd  in  REG_AW  destination register.
- aluResult  in  DATA_W  ALU output.
- pc  in  DATA_W  instruction PC.
- ld_valid  in  1  load data valid this cycle.
- ldResult  in  DATA_W  load data.
- flush  in  1  kill the held entry.
- rs1, rs2  in  REG_AW  read addresses.
- rd1, rd2  out  DATA_W  read data, combinational, with bypass.
- isWa  out  1  register write enable this cycle.
- wa  out  REG_AW  write address.
- wd  out  DATA_W  write data.
- busy  out  1  entry held (FULL or WAIT_LD).
- ld_orphan  out  1  sticky: ld_valid seen with no load pending.

Behaviour:
- States:
  - EMPTY: no entry.
  - FULL: non-load entry held.
  - WAIT_LD: load entry waiting for data.
- Entry register holds isWb, isLd, isCall, rd, aluResult and pc.
- commit = (state==FULL) | (state==WAIT_LD & ld_valid), gated by ~flush.
- in_ready = ~flush & (state==EMPTY | commit).
- Accept = in_valid & in_ready. Accept captures the inputs at the edge.
  - Next state is WAIT_LD if isLd, else FULL.
  - Without accept, a committing entry goes to EMPTY.
- Throughput is one instruction per cycle for non-loads. Latency from accept edge to commit cycle is 1 cycle for a non-load. For a load it is 1 cycle plus the ld_valid delay.
- ld_valid arriving in the same cycle as a load's accept is not used by that load. The load captures data in a later cycle.
- WAIT_LD holds indefinitely with in_ready=0 until ld_valid.
- Write port during a commit cycle (all combinational from the entry):
  - isWa = entry.isWb, and 0 if ZERO_REG_EN and wa==0.
  - wa = entry.isCall ? RA_IDX : entry.rd.
  - wd = entry.isCall ? pc+PC_INC (mod 2^DATA_W) : entry.isLd ? ldResult : aluResult.
- Outside commit cycles, isWa, wa and wd are driven 0.
- Register file write takes effect at the edge ending the commit cycle.
- A call instruction writes only if isWb=1. The decoder sets isWb for calls.
- Read ports: rdN = regfile[rsN], except:
  - If isWa & wa==rsN in the same cycle, rdN = wd (write-through bypass).
  - ZERO_REG_EN & rsN==0 forces 0.
- flush:
  - The entry is discarded with no write; state becomes EMPTY.
  - in_ready=0, so no accept in that cycle.
  - A coincident ld_valid is consumed and dropped, and does not set ld_orphan.
- ld_orphan:
  - Set when ld_valid=1 while state!=WAIT_LD and not flushing.
  - Stays set until rst.
  - No other effect.
- Reset, including reset asserted mid-WAIT_LD:
  - state EMPTY, all registers 0, entry cleared, ld_orphan 0.
  - Outputs: in_ready 1, busy 0, isWa/wa/wd 0.
  - A late ld_valid after reset sets ld_orphan.

Decomposition:
- Shared package wb_pkg holds:
  - state enum (EMPTY, FULL, WAIT_LD);
  - default constants for DATA_W, NUM_REGS, RA_IDX, PC_INC;
  - struct for the entry fields.
- One sub-module: wb_regfile, parametrised NUM_REGS x DATA_W. It has one write port, two bypassed read ports, async reset to 0 and the ZERO_REG_EN handling.
- Writeback select, FSM and entry register live in the top module.

Test Plan:
- Call: isCall=1, isWb=1, rd=2, pc=0x10, aluResult=0xAAAAAAAA -> next cycle isWa=1, wa=15, wd=0x14. rs1=15 in that cycle returns 0x14 via bypass, and returns 0x14 from the regfile afterwards.
- Load, 3-cycle data: isLd=1, rd=3, aluResult=0xCCCCCCCC, ld_valid pulsed 3 cycles after accept with ldResult=0xDDDDDDDD.
  - busy=1 and in_ready=0 throughout the wait.
  - Single commit wa=3, wd=0xDDDDDDDD.
  - The ALU value is never written.
- Back-to-back ALU: rd=4/0xEEEEEEEE then rd=5/0x11111111 on consecutive cycles -> in_ready stays 1 and there are two consecutive commits. With isWb=0 on the second, isWa=0 and r5 is unchanged.
- Flush in WAIT_LD with coincident ld_valid: load to rd=6 pending, then flush=1 and ld_valid=1 together -> no write, r6 keeps its value, EMPTY next cycle, ld_orphan=0.
- Orphan/reset: rst asserted mid-WAIT_LD -> all outputs 0, r0..r15=0. ld_valid next cycle -> ld_orphan=1 and sticky.
- ZERO_REG_EN=1, NUM_REGS=32, DATA_W=64: write rd=0 value 0x1 -> isWa=0, rd1(rs1=0)=0. Call with pc=0xFFFFFFFFFFFFFFFE -> wd=0x2 (wraps).
